// File: rtl/core_mem_arb.sv
// core_mem_arb: arbitrates a CPU port and a host port onto one 32-bit memory.
// One transaction in flight; reads return after a fixed memory latency.
module core_mem_arb #(
    parameter int ADDR_WIDTH    = 12,
    parameter int RD_LATENCY    = 1,
    parameter int HOST_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           c_address,
    input  logic                  c_read,
    input  logic                  c_write,
    input  logic [31:0]           c_writedata,
    input  logic [3:0]            c_byteenable,
    output logic [31:0]           c_readdata,
    output logic                  c_waitrequest,
    input  logic [ADDR_WIDTH-1:0] h_address,
    input  logic                  h_read,
    input  logic                  h_write,
    input  logic [31:0]           h_writedata,
    output logic                  h_waitrequest,
    output logic [31:0]           h_readdata,
    output logic                  h_readdatavalid,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_wr,
    output logic                  m_rd,
    output logic [3:0]            m_be,
    output logic [31:0]           m_wdata,
    input  logic [31:0]           m_rdata,
    input  logic                  clr_err,
    output logic                  oob_err
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t     state, state_nx;
    logic       src_host, is_wr, is_oob, last_host;
    logic [2:0] cnt;
    logic       c_req, h_req, c_oob, host_wins;
    logic       grant_h, grant_c, rd_done;
    logic       unused_addr_lsb;

    assign c_req           = c_read | c_write;
    assign h_req           = h_read | h_write;
    assign c_oob           = |c_address[31:ADDR_WIDTH+2];
    assign unused_addr_lsb = ^c_address[1:0];
    assign rd_done         = (state == WAIT) && (cnt == LAT);

    // Round-robin favours whoever was not granted last.
    always_comb begin
        host_wins = (HOST_PRIORITY != 0) || !last_host;
        grant_h   = (state == IDLE) && h_req && (!c_req || host_wins);
        grant_c   = (state == IDLE) && c_req && !grant_h;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        c_waitrequest = c_req;
        h_waitrequest = 1'b1;
        unique case (state)
            IDLE: begin
                h_waitrequest = !grant_h;
                if (grant_h || grant_c) state_nx = CMD;
            end
            CMD: begin
                if (is_wr || is_oob) begin
                    state_nx = IDLE;
                    if (!src_host) c_waitrequest = 1'b0;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (rd_done) state_nx = RESP;
            end
            RESP: begin
                state_nx = IDLE;
                if (!src_host) c_waitrequest = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_host        <= 1'b0;
            is_wr           <= 1'b0;
            is_oob          <= 1'b0;
            last_host       <= 1'b0;
            cnt             <= '0;
            m_addr          <= '0;
            m_be            <= '0;
            m_wdata         <= '0;
            m_wr            <= 1'b0;
            m_rd            <= 1'b0;
            c_readdata      <= '0;
            h_readdata      <= '0;
            h_readdatavalid <= 1'b0;
            oob_err         <= 1'b0;
        end else begin
            m_wr            <= 1'b0;
            m_rd            <= 1'b0;
            h_readdatavalid <= 1'b0;
            if (grant_h) begin
                src_host  <= 1'b1;
                is_wr     <= h_write;
                is_oob    <= 1'b0;
                last_host <= 1'b1;
                m_addr    <= h_address;
                m_be      <= 4'hF;
                m_wdata   <= h_writedata;
                m_wr      <= h_write;
                m_rd      <= !h_write;
            end else if (grant_c) begin
                src_host  <= 1'b0;
                is_wr     <= c_write;
                is_oob    <= c_oob;
                last_host <= 1'b0;
                m_addr    <= c_address[ADDR_WIDTH+1:2];
                m_be      <= c_byteenable;
                m_wdata   <= c_writedata;
                m_wr      <= c_write && !c_oob;
                m_rd      <= !c_write && !c_oob;
                if (c_oob && !c_write) c_readdata <= '0;
            end
            if (state == CMD)       cnt <= 3'd1;
            else if (state == WAIT) cnt <= cnt + 3'd1;
            if (rd_done) begin
                if (src_host) begin
                    h_readdata      <= m_rdata;
                    h_readdatavalid <= 1'b1;
                end else begin
                    c_readdata <= m_rdata;
                end
            end
            // A new out-of-range access beats a simultaneous clear.
            if (grant_c && c_oob) oob_err <= 1'b1;
            else if (clr_err)     oob_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_mem_arb.sv
// tb_core_mem_arb: directed and random CPU/host traffic against a
// fixed-latency memory, checked with a word-level reference model.
module tb_core_mem_arb;

    localparam int AW  = 12;
    localparam int LAT = 3;
    localparam int DEP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   c_address = '0;
    logic          c_read = 1'b0;
    logic          c_write = 1'b0;
    logic [31:0]   c_writedata = '0;
    logic [3:0]    c_byteenable = '0;
    logic [31:0]   c_readdata;
    logic          c_waitrequest;
    logic [AW-1:0] h_address = '0;
    logic          h_read = 1'b0;
    logic          h_write = 1'b0;
    logic [31:0]   h_writedata = '0;
    logic          h_waitrequest;
    logic [31:0]   h_readdata;
    logic          h_readdatavalid;
    logic [AW-1:0] m_addr;
    logic          m_wr, m_rd;
    logic [3:0]    m_be;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;
    logic          clr_err = 1'b0;
    logic          oob_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_mem_arb #(
        .ADDR_WIDTH(AW), .RD_LATENCY(LAT), .HOST_PRIORITY(0)
    ) dut (
        .clk(clk), .reset(reset),
        .c_address(c_address), .c_read(c_read), .c_write(c_write),
        .c_writedata(c_writedata), .c_byteenable(c_byteenable),
        .c_readdata(c_readdata), .c_waitrequest(c_waitrequest),
        .h_address(h_address), .h_read(h_read), .h_write(h_write),
        .h_writedata(h_writedata), .h_waitrequest(h_waitrequest),
        .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid),
        .m_addr(m_addr), .m_wr(m_wr), .m_rd(m_rd), .m_be(m_be),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .clr_err(clr_err), .oob_err(oob_err)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'h5A5A_0000 ^ (32'(i) * 32'h0100_0193);
    endfunction

    // Memory device: data valid LAT cycles after the m_rd cycle.
    logic [31:0]   dev_mem [DEP];
    logic [LAT-1:0] pv;
    logic [AW-1:0] pa [LAT];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEP; i++) dev_mem[i] <= init_word(i);
            pv <= '0;
        end else begin
            if (m_wr)
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) dev_mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            pv <= {pv[LAT-2:0], m_rd};
        end
        pa[0] <= m_addr;
        for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end

    assign m_rdata = pv[LAT-1] ? dev_mem[pa[LAT-1]] : 32'hBAD0_BAD0;

    logic [31:0] ref_mem [DEP];
    logic        ref_oob = 1'b0;

    task automatic ref_init();
        for (int i = 0; i < DEP; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU access, started right after a tick, ended right after a tick.
    task automatic cpu_check(input string tag, input logic [31:0] a,
                             input logic wr, input logic [31:0] d,
                             input logic [3:0] be, input logic clr);
        int            ncyc, ncmd;
        logic [31:0]   rd, cd;
        logic [AW-1:0] ca, w;
        logic [3:0]    cb;
        logic          oob;
        oob = |a[31:AW+2];
        w   = a[AW+1:2];
        ncyc = 0; ncmd = 0; rd = '0; cd = '0; ca = '0; cb = '0;
        c_address = a; c_write = wr; c_read = !wr;
        c_writedata = d; c_byteenable = be; clr_err = clr;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (m_wr || m_rd) begin
                ncmd++; ca = m_addr; cb = m_be; cd = m_wdata;
            end
            if (!c_waitrequest) begin
                ncyc = i; rd = c_readdata;
                break;
            end
            tick();
            clr_err = 1'b0;
        end
        tick();
        c_read = 1'b0; c_write = 1'b0; clr_err = 1'b0;
        chk({tag, "_cyc"}, ncyc, (oob || wr) ? 2 : LAT + 3);
        chk({tag, "_ncmd"}, ncmd, oob ? 0 : 1);
        if (!oob) begin
            chk({tag, "_maddr"}, ca, w);
            chk({tag, "_mbe"}, cb, be);
            if (wr) chk({tag, "_mwdata"}, cd, d);
        end
        if (!wr) chk({tag, "_rdata"}, rd, oob ? 32'h0 : ref_mem[w]);
        if (clr) ref_oob = 1'b0;
        if (oob) ref_oob = 1'b1;
        else if (wr)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        @(negedge clk);
        chk({tag, "_oob"}, oob_err, ref_oob);
        tick();
    endtask

    task automatic host_check(input string tag, input logic [AW-1:0] w,
                              input logic wr, input logic [31:0] d);
        int            acc, npulse, at, nw, nr;
        logic [31:0]   hd, cd;
        logic [AW-1:0] ca;
        logic [3:0]    cb;
        acc = 0; npulse = 0; at = 0; nw = 0; nr = 0;
        hd = '0; cd = '0; ca = '0; cb = '0;
        h_address = w; h_write = wr; h_read = !wr; h_writedata = d;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!h_waitrequest) begin
                acc = i;
                break;
            end
            tick();
        end
        tick();
        h_read = 1'b0; h_write = 1'b0;
        for (int j = 1; j <= LAT + 5; j++) begin
            @(negedge clk);
            if (m_wr) begin nw++; ca = m_addr; cb = m_be; cd = m_wdata; end
            if (m_rd) begin nr++; ca = m_addr; cb = m_be; end
            if (h_readdatavalid) begin npulse++; at = j; hd = h_readdata; end
            tick();
        end
        chk({tag, "_acc"}, acc, 1);
        chk({tag, "_nwr"}, nw, wr ? 1 : 0);
        chk({tag, "_nrd"}, nr, wr ? 0 : 1);
        chk({tag, "_maddr"}, ca, w);
        chk({tag, "_mbe"}, cb, 4'hF);
        if (wr) begin
            chk({tag, "_mwdata"}, cd, d);
            ref_mem[w] = d;
        end else begin
            chk({tag, "_npulse"}, npulse, 1);
            chk({tag, "_at"}, at, LAT + 2);
            chk({tag, "_hdata"}, hd, ref_mem[w]);
        end
    endtask

    task automatic clr_pulse(input string tag);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        ref_oob = 1'b0;
        @(negedge clk);
        chk(tag, oob_err, ref_oob);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [AW-1:0] w;
        logic [31:0]   a;
        ref_init();
        tick();
        tick();
        @(negedge clk);
        chk("rst_regs",
            {m_wr, m_rd, h_readdatavalid, oob_err, m_be} | m_addr |
            m_wdata | c_readdata | h_readdata, 0);
        chk("rst_hwait", h_waitrequest, 1);
        chk("rst_cwait", c_waitrequest, 0);
        tick();
        reset = 1'b0;
        tick();

        // First tie after reset goes to the host, the next one to the CPU.
        h_address = 12'h020; h_write = 1'b1; h_writedata = 32'h1111_0001;
        c_address = 32'h88; c_write = 1'b1; c_writedata = 32'hC0C0_0022;
        c_byteenable = 4'hF;
        @(negedge clk);
        chk("tie1_hwait", h_waitrequest, 0);
        chk("tie1_cwait", c_waitrequest, 1);
        tick();
        h_address = 12'h021; h_writedata = 32'h2222_0002;
        @(negedge clk);
        chk("tie1_cmd", {m_wr, m_addr}, {1'b1, 12'h020});
        tick();
        @(negedge clk);
        chk("tie2_hwait", h_waitrequest, 1);
        tick();
        @(negedge clk);
        chk("tie2_cwait", c_waitrequest, 0);
        chk("tie2_cmd", {m_wr, m_addr}, {1'b1, 12'h022});
        tick();
        c_write = 1'b0;
        @(negedge clk);
        chk("tie3_hwait", h_waitrequest, 0);
        tick();
        h_write = 1'b0;
        @(negedge clk);
        chk("tie3_cmd", {m_wr, m_addr}, {1'b1, 12'h021});
        tick();
        ref_mem[12'h020] = 32'h1111_0001;
        ref_mem[12'h021] = 32'h2222_0002;
        ref_mem[12'h022] = 32'hC0C0_0022;

        host_check("h_w4", 12'h004, 1'b1, 32'h1234_5678);
        cpu_check("c_rd4", 32'h10, 1'b0, 32'h0, 4'hF, 1'b0);
        cpu_check("c_wr4", 32'h10, 1'b1, 32'hDEAD_BEEF, 4'h3, 1'b0);
        cpu_check("c_rd4b", 32'h10, 1'b0, 32'h0, 4'hF, 1'b0);
        host_check("h_w3ff", 12'h3FF, 1'b1, 32'hA5C3_0FF0);
        host_check("h_r3ff", 12'h3FF, 1'b0, 32'h0);
        cpu_check("oob_rd", 32'h0001_0000, 1'b0, 32'h0, 4'hF, 1'b1);
        clr_pulse("oob_clr");

        // CPU drops its strobe after grant; the read still completes once.
        c_address = 32'h10; c_read = 1'b1;
        @(negedge clk);
        tick();
        c_read = 1'b0;
        n = 0;
        for (int j = 1; j <= LAT + 5; j++) begin
            @(negedge clk);
            if (m_rd || m_wr) n++;
            tick();
        end
        chk("drop_ncmd", n, 1);
        @(negedge clk);
        chk("drop_hold", c_readdata, ref_mem[4]);
        tick();

        // Reset while a host read sits in WAIT.
        h_address = 12'h3FF; h_read = 1'b1;
        @(negedge clk);
        chk("abort_acc", h_waitrequest, 0);
        tick();
        h_read = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("abort_regs", {m_rd, m_wr, h_readdatavalid, oob_err}, 0);
        chk("abort_hdata", h_readdata, 0);
        tick();
        reset = 1'b0;
        ref_init();
        ref_oob = 1'b0;
        n = 0;
        for (int j = 1; j <= LAT + 6; j++) begin
            @(negedge clk);
            if (h_readdatavalid || m_rd || m_wr || c_waitrequest) n++;
            tick();
        end
        chk("abort_quiet", n, 0);
        host_check("post_h", 12'h3FF, 1'b0, 32'h0);
        cpu_check("post_c", 32'h44, 1'b0, 32'h0, 4'hF, 1'b0);

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(0, 19);
            w = (n < 16) ? AW'(n) : (n < 19) ? AW'(32 + n - 16) : 12'h3FF;
            n = $urandom_range(0, 9);
            if (n <= 3) begin
                a = {18'h0, w, 2'($urandom)};
                cpu_check("rnd_c", a, 1'($urandom), $urandom,
                          4'($urandom), 1'b0);
            end else if (n == 4) begin
                a = $urandom | (32'h1 << $urandom_range(AW + 2, 31));
                cpu_check("rnd_oob", a, 1'($urandom), $urandom, 4'hF, 1'b0);
            end else if (n <= 8) begin
                host_check("rnd_h", w, 1'($urandom), $urandom);
            end else begin
                clr_pulse("rnd_clr");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
